// File: rtl/bibuff_pkg.sv
// rtl/bibuff_pkg.sv - shared state encoding and limits for the bidirectional buffer
package bibuff_pkg;

    localparam int TURN_CYC_MAX = 15;
    localparam int CNT_W        = 4;

    typedef enum logic [1:0] {
        ST_HIZ  = 2'd0,
        ST_B2A  = 2'd1,
        ST_A2B  = 2'd2,
        ST_TURN = 2'd3
    } bibuff_state_t;

    function automatic logic is_undriven(input bibuff_state_t st);
        return (st == ST_HIZ) || (st == ST_TURN);
    endfunction

endpackage

// File: rtl/bibuff.sv
// rtl/bibuff.sv - direction-switched bidirectional buffer with all-high-Z turnaround
module bibuff
    import bibuff_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int TURN_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    inout  wire  [WIDTH-1:0] a,
    inout  wire  [WIDTH-1:0] b,
    input  logic             En,
    output logic             dir,
    output logic             hiz
);

    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYC - 1);

    bibuff_state_t    state;
    bibuff_state_t    state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_HIZ;
            cnt   <= '0;
            dir   <= 1'b0;
            hiz   <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dir   <= (state_nxt == ST_B2A);
            hiz   <= is_undriven(state_nxt);
        end
    end

    // En toggles inside TURN are ignored until the counter expires.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_HIZ: begin
                state_nxt = En ? ST_B2A : ST_A2B;
            end
            ST_B2A: begin
                if (!En) begin
                    state_nxt = ST_TURN;
                    cnt_nxt   = TURN_LOAD;
                end
            end
            ST_A2B: begin
                if (En) begin
                    state_nxt = ST_TURN;
                    cnt_nxt   = TURN_LOAD;
                end
            end
            ST_TURN: begin
                if (cnt == '0) begin
                    state_nxt = En ? ST_B2A : ST_A2B;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_HIZ;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Drivers decode the async-reset state register, so reset releases both sides at once.
    assign a = (state == ST_B2A) ? b : {WIDTH{1'bz}};
    assign b = (state == ST_A2B) ? a : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bibuff.sv
// tb/tb_bibuff.sv - directed self-checking bench for bibuff
module tb_bibuff;

    localparam int W = 8;
    localparam int T = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         dir;
    logic         hiz;
    logic [W-1:0] a_drv;
    logic [W-1:0] b_drv;
    logic         a_oe;
    logic         b_oe;
    wire  [W-1:0] a;
    wire  [W-1:0] b;

    int total = 0;
    int bad   = 0;

    assign a = a_oe ? a_drv : {W{1'bz}};
    assign b = b_oe ? b_drv : {W{1'bz}};

    bibuff #(.WIDTH(W), .TURN_CYC(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .En    (en),
        .dir   (dir),
        .hiz   (hiz)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Both sides held by the bench with opposing patterns: any DUT drive corrupts one.
    task automatic chk_float(input string tag);
        chk({tag, "_a"}, 32'(a), 32'(a_drv));
        chk({tag, "_b"}, 32'(b), 32'(b_drv));
        chk({tag, "_hiz"}, 32'(hiz), 32'd1);
        chk({tag, "_dir"}, 32'(dir), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        a_oe  = 1'b1;
        b_oe  = 1'b1;
        a_drv = 8'h00;
        b_drv = 8'hFF;

        // reset: nothing driven, external values read back in both polarities
        repeat (2) tick();
        chk_float("rst0");
        a_drv = 8'hFF;
        b_drv = 8'h00;
        #1;
        chk_float("rst1");

        // forward pass
        en    = 1'b1;
        a_oe  = 1'b0;
        b_drv = 8'h00;
        #1;
        rst_n = 1'b1;
        tick();
        chk("fwd_dir", 32'(dir), 32'd1);
        chk("fwd_hiz", 32'(hiz), 32'd0);
        chk("fwd_a0", 32'(a), 32'h00);
        b_drv = 8'hFF;
        #1;
        chk("fwd_a1", 32'(a), 32'hFF);
        b_drv = 8'h5A;
        #1;
        chk("fwd_a2", 32'(a), 32'h5A);
        chk("fwd_b", 32'(b), 32'h5A);

        // async reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_hiz", 32'(hiz), 32'd1);
        chk("arst_dir", 32'(dir), 32'd0);
        a_oe  = 1'b1;
        a_drv = 8'h0F;
        b_drv = 8'hF0;
        #1;
        chk_float("arst");

        // reverse pass
        en    = 1'b0;
        b_oe  = 1'b0;
        a_drv = 8'h01;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rev_dir", 32'(dir), 32'd0);
        chk("rev_hiz", 32'(hiz), 32'd0);
        chk("rev_b0", 32'(b), 32'h01);
        a_drv = 8'hA5;
        #1;
        chk("rev_b1", 32'(b), 32'hA5);

        // turnaround B2A -> A2B
        rst_n = 1'b0;
        en    = 1'b1;
        a_oe  = 1'b0;
        b_oe  = 1'b1;
        b_drv = 8'hF0;
        #1;
        rst_n = 1'b1;
        tick();
        chk("ta_b2a_dir", 32'(dir), 32'd1);
        chk("ta_b2a_a", 32'(a), 32'hF0);
        en = 1'b0;
        tick();
        a_oe  = 1'b1;
        a_drv = 8'h0F;
        #1;
        chk_float("ta_e0");
        tick();
        chk_float("ta_e1");
        tick();
        chk_float("ta_e2");
        b_oe = 1'b0;
        tick();
        chk("ta_e3_hiz", 32'(hiz), 32'd0);
        chk("ta_e3_dir", 32'(dir), 32'd0);
        chk("ta_e3_b", 32'(b), 32'h0F);

        // En glitch inside TURN, final value 0 -> A2B
        en = 1'b1;
        tick();
        b_oe  = 1'b1;
        b_drv = 8'hF0;
        en    = 1'b0;
        #1;
        chk_float("gl_e0");
        tick();
        en = 1'b1;
        chk_float("gl_e1");
        tick();
        en = 1'b0;
        chk_float("gl_e2");
        b_oe = 1'b0;
        tick();
        chk("gl_e3_hiz", 32'(hiz), 32'd0);
        chk("gl_e3_dir", 32'(dir), 32'd0);
        chk("gl_e3_b", 32'(b), 32'h0F);

        // A2B -> B2A turnaround
        en = 1'b1;
        tick();
        b_oe  = 1'b1;
        b_drv = 8'h3C;
        #1;
        chk_float("ba_e0");
        tick();
        chk_float("ba_e1");
        tick();
        chk_float("ba_e2");
        a_oe = 1'b0;
        tick();
        chk("ba_e3_dir", 32'(dir), 32'd1);
        chk("ba_e3_hiz", 32'(hiz), 32'd0);
        chk("ba_e3_a", 32'(a), 32'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
